uart_tx_queue: RTL and testbench

Byte FIFO and launcher upstream of the UART transmitter. Producers push bytes at clock rate; the block buffers them and hands one byte at a time to the transmitter through its `start`/`txin`/`txdone` handshake. It then enforces a guard gap before launching the next byte, so back-to-back bytes go out without software pacing.

---
 rtl/uart_tx_queue.sv | 154 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO and launcher for the UART transmitter: pops one byte at a time, pulses start,
// waits for txdone, then holds off GAP cycles. UART_TXQ_OVF_EN adds a sticky overflow flag.
//
// state  | meaning
// S_IDLE | waiting for a queued byte; pops it into txin on exit
// S_LOAD | start pulse cycle, txin valid
// S_WAIT | transmitter busy, waiting for txdone
// S_GAP  | guard gap down-count before the next launch
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          start,
    output logic [7:0]    txin,
`ifdef UART_TXQ_OVF_EN
    output logic          ovf,
    input  logic          ovf_clr,
`endif
    input  logic          txdone,
    output logic          busy
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
    localparam logic [GW-1:0] GCNT_ONE = GW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    txin_q, txin_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign txin  = txin_q;
    // Decoded from the state flop so reset kills start without waiting for an edge.
    assign start = (state_q == S_LOAD);
    assign busy  = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        txin_d  = txin_q;
        gcnt_d  = gcnt_q;
        push    = wr_en && !full;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    txin_d  = mem_q[rp_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (txdone) begin
                    gcnt_d  = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GCNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            rp_d = rp_q + PTR_ONE;
        end
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            txin_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            txin_q  <= txin_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a directed vector table for single-byte launches plus
// hand-written sequences for back-to-back, fill/overflow, wrap-around and reset cases.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GAP   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          txdone = 1'b0;
    logic          full, empty, start, busy;
    logic [AW:0]   level;
    logic [7:0]    txin;
`ifdef UART_TXQ_OVF_EN
    logic          ovf;
    logic          ovf_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] starts_q [$];
    int         start_cyc [$];

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       td;
        logic [4:0] lvl;
        logic       st;
        logic       bs;
        logic [7:0] tx;
    } vec_t;
    vec_t tv [21];

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .start   (start),
        .txin    (txin),
`ifdef UART_TXQ_OVF_EN
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
`endif
        .txdone  (txdone),
        .busy    (busy)
    );

    // Log every launch with the edge number it followed.
    always @(posedge clk) begin
        #1;
        if (start) begin
            starts_q.push_back(txin);
            start_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic wait_start(input int n);
        for (int i = 0; i < 200 && starts_q.size() < n; i++) step();
        check("start_timeout", 32'(starts_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) step();
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t_done;
        int nxt, wc, ms, mc;
        int mq [$];
        logic [7:0] mtx;

        tv[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
        tv[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 8'hA5};
        tv[4]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5};
        tv[6]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5};
        tv[7]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'hA5};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5};
        tv[9]  = '{1'b1, 8'h5A, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
        tv[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
        tv[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[13] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[14] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[15] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[16] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[17] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[18] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[19] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h5A};
        tv[20] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'h5A};

        // Reset, then idle with nothing queued.
        rst = 1'b1;
        repeat (3) step();
        check("rst_start", 32'(start), 32'd0);
        check("rst_txin",  32'(txin),  32'h00);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
`ifdef UART_TXQ_OVF_EN
        check("rst_ovf",   32'(ovf),   32'd0);
`endif
        rst = 1'b0;
        repeat (100) step();
        check("idle_no_start", 32'(starts_q.size()), 32'd0);
        check("idle_busy",     32'(busy),            32'd0);

        // Single-byte launches from the vector table.
        for (int i = 0; i < 21; i++) begin
            wr_en   = tv[i].we;
            wr_data = tv[i].wd;
            txdone  = tv[i].td;
            step();
            check($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].lvl));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(tv[i].lvl == 5'd0));
            check($sformatf("vec%0d_full",  i), 32'(full),  32'd0);
            check($sformatf("vec%0d_start", i), 32'(start), 32'(tv[i].st));
            check($sformatf("vec%0d_busy",  i), 32'(busy),  32'(tv[i].bs));
            check($sformatf("vec%0d_txin",  i), 32'(txin),  32'(tv[i].tx));
        end
        wr_en = 1'b0;
        txdone = 1'b0;

        // Back-to-back: three bytes, each launch GAP+1 edges after the txdone edge.
        base = starts_q.size();
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        t_done = 0;
        for (int k = 0; k < 3; k++) begin
            wait_start(base + k + 1);
            if (starts_q.size() > base + k) begin
                check("b2b_txin", 32'(starts_q[base+k]), 32'(k + 1));
                if (k > 0) check("b2b_spacing", 32'(start_cyc[base+k] - t_done), 32'(GAP + 1));
            end
            repeat (20) step();
            txdone = 1'b1;
            step();
            t_done = cyc;
            txdone = 1'b0;
        end
        wait_idle();
        check("b2b_count", 32'(starts_q.size() - base), 32'd3);

        // Fill to DEPTH with the transmitter stalled, then overflow.
        base = starts_q.size();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        check("fill_level", 32'(level), 32'd16);
        check("fill_full",  32'(full),  32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        wr_data = 8'hEE;
        step();
        check("drop_level", 32'(level), 32'd16);
        check("drop_full",  32'(full),  32'd1);
`ifdef UART_TXQ_OVF_EN
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        check("ovf_set_priority", 32'(ovf), 32'd1);
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        step();
        check("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        check("ovf_clear", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
`endif
        wr_en = 1'b0;
        for (int k = 0; k < 17; k++) begin
            wait_start(base + k + 1);
            if (starts_q.size() > base + k)
                check("fill_order", 32'(starts_q[base+k]), 32'(8'h10 + k));
            repeat (3) step();
            txdone = 1'b1;
            step();
            txdone = 1'b0;
        end
        wait_idle();
        check("fill_drained_empty", 32'(empty), 32'd1);
        check("fill_count", 32'(starts_q.size() - base), 32'd17);

        // Wrap-around stream against a cycle model of queue and launcher.
        base = starts_q.size();
        nxt = 0; wc = 0; ms = 0; mc = 0;
        mq.delete();
        mtx = 8'h20;
        for (int c = 0; c < 3000 && !(nxt == 40 && mq.size() == 0 && ms == 0); c++) begin
            logic we;
            logic td;
            int   sz;
            sz = mq.size();
            we = (nxt < 40) && (sz < DEPTH) && ((c % 5) != 4);
            td = (ms == 2) && (wc >= 3);
            wr_en = we;
            wr_data = 8'(nxt);
            txdone = td;
            if (ms == 0 && sz > 0) mtx = 8'(mq.pop_front());
            if (we) begin
                mq.push_back(nxt);
                nxt++;
            end
            case (ms)
                0: if (sz > 0) ms = 1;
                1: begin ms = 2; wc = 0; end
                2: if (td) begin ms = 3; mc = GAP - 1; end else wc++;
                default: if (mc == 0) ms = 0; else mc--;
            endcase
            step();
            check("wrap_level", 32'(level), 32'(mq.size()));
            check("wrap_start", 32'(start), 32'(ms == 1));
            check("wrap_txin",  32'(txin),  32'(mtx));
        end
        wr_en = 1'b0;
        txdone = 1'b0;
        check("wrap_done", 32'(nxt == 40 && mq.size() == 0 && ms == 0), 32'd1);
        check("wrap_count", 32'(starts_q.size() - base), 32'd40);
        for (int i = 0; i < 40 && base + i < starts_q.size(); i++)
            check("wrap_order", 32'(starts_q[base+i]), 32'(i));

        // Reset in WAIT with five bytes queued.
        base = starts_q.size();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h61 + i);
            step();
        end
        wr_en = 1'b0;
        check("pre_rst_level", 32'(level), 32'd5);
        check("pre_rst_busy",  32'(busy),  32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_start", 32'(start), 32'd0);
        check("rst_wait_level", 32'(level), 32'd0);
        check("rst_wait_busy",  32'(busy),  32'd0);
        check("rst_wait_empty", 32'(empty), 32'd1);
        step();
        rst = 1'b0;
        repeat (20) step();
        check("post_rst_no_launch", 32'(starts_q.size() - base), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Reset during the start pulse drops start at once.
        wr_en = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        check("load_start", 32'(start), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_load_start", 32'(start), 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        check("post_rst2_busy", 32'(busy), 32'd0);

        // A fresh push launches normally after reset.
        base = starts_q.size();
        wr_en = 1'b1;
        wr_data = 8'h88;
        step();
        wr_en = 1'b0;
        wait_start(base + 1);
        if (starts_q.size() > base) check("post_rst_txin", 32'(starts_q[base]), 32'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
